// File: rtl/noc_endpoint_tx_if.sv
// Bundle of the client flit stream, the router local-input port and the
// status outputs of one endpoint transmitter.
interface noc_endpoint_tx_if #(
    parameter int FLIT_WIDTH        = 256,
    parameter int DEST_WIDTH        = 4,
    parameter int FLIT_BUFFER_DEPTH = 2
);
    localparam int CNT_WIDTH = $clog2(FLIT_BUFFER_DEPTH + 1);

    // Client side
    logic [FLIT_WIDTH-1:0] in_data;
    logic [DEST_WIDTH-1:0] in_dest;
    logic                  in_last;
    logic                  in_valid;
    logic                  in_ready;

    // Router local input port
    logic                  send_out;
    logic [FLIT_WIDTH-1:0] data_out;
    logic [DEST_WIDTH-1:0] dest_out;
    logic                  is_tail_out;
    logic                  credit_in;

    // Status
    logic [CNT_WIDTH-1:0]  credits_avail;
    logic                  in_packet;
    logic                  err_credit_ovf;

    // Environment view: drives the client flits and credit returns
    modport master (
        output in_data, in_dest, in_last, in_valid, credit_in,
        input  in_ready, send_out, data_out, dest_out, is_tail_out,
        input  credits_avail, in_packet, err_credit_ovf
    );

    // Transmitter view
    modport slave (
        input  in_data, in_dest, in_last, in_valid, credit_in,
        output in_ready, send_out, data_out, dest_out, is_tail_out,
        output credits_avail, in_packet, err_credit_ovf
    );
endinterface

// File: rtl/noc_endpoint_tx.sv
// Credit-based flit injector for a ring NoC endpoint. Accepts a valid/ready
// client stream, forwards each accepted flit to the router one cycle later,
// and keeps the head flit's destination for every flit of a wormhole packet.
module noc_endpoint_tx #(
    parameter int FLIT_WIDTH        = 256,
    parameter int DEST_WIDTH        = 4,
    parameter int FLIT_BUFFER_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    noc_endpoint_tx_if.slave  bus
);
    localparam int CNT_WIDTH = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(FLIT_BUFFER_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic {
        ST_IDLE,
        ST_PACKET
    } state_t;

    state_t                r_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_err;
    logic [DEST_WIDTH-1:0] r_dest_lock;
    logic                  r_send;
    logic [FLIT_WIDTH-1:0] r_data;
    logic [DEST_WIDTH-1:0] r_dest;
    logic                  r_tail;

    logic                  w_ready;
    logic                  w_fire;

    // Ready depends only on the registered credit count (and reset), so there
    // is no combinational path from in_valid or credit_in.
    assign w_ready = (r_cnt != '0) && !rst;
    assign w_fire  = bus.in_valid && w_ready;

    // Credit counter: one credit spent per accepted flit, one regained per
    // credit_in pulse; an extra credit at full count is flagged, not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= CNT_FULL;
            r_err <= 1'b0;
        end else begin
            case ({w_fire, bus.credit_in})
                2'b10: r_cnt <= r_cnt - CNT_ONE;
                2'b01: begin
                    if (r_cnt == CNT_FULL) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Framing FSM with registered router-side outputs; payload and tag hold
    // their last values whenever no flit is emitted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_dest_lock <= '0;
            r_send      <= 1'b0;
            r_data      <= '0;
            r_dest      <= '0;
            r_tail      <= 1'b0;
        end else begin
            r_send <= w_fire;
            if (w_fire) begin
                r_data <= bus.in_data;
                r_tail <= bus.in_last;
                case (r_state)
                    ST_IDLE: begin
                        r_dest <= bus.in_dest;
                        if (!bus.in_last) begin
                            r_dest_lock <= bus.in_dest;
                            r_state     <= ST_PACKET;
                        end
                    end
                    ST_PACKET: begin
                        r_dest <= r_dest_lock;
                        if (bus.in_last) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.in_ready       = w_ready;
    assign bus.send_out       = r_send;
    assign bus.data_out       = r_data;
    assign bus.dest_out       = r_dest;
    assign bus.is_tail_out    = r_tail;
    assign bus.credits_avail  = r_cnt;
    assign bus.in_packet      = (r_state == ST_PACKET);
    assign bus.err_credit_ovf = r_err;

endmodule
